// File: rtl/qerv_rf_pkg.sv
// Shared sizing helpers and state encodings for the RF-RAM scheduler.
package qerv_rf_pkg;

  // Register address width: 32 GPRs plus the CSR block.
  function automatic int rf_raw(input int csr_regs);
    return $clog2(32 + csr_regs);
  endfunction

  // RAM word address width: register bits plus 5 bit-index bits, minus the bits packed per word.
  function automatic int rf_aw(input int width, input int csr_regs);
    return 5 + rf_raw(csr_regs) - $clog2(width);
  endfunction

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  typedef enum logic {D_IDLE, D_WAIT} dstate_t;

endpackage

// File: rtl/qerv_rf_clr_seq.sv
// Post-reset clear sequencer: walks every RAM word address once, then idles.
module qerv_rf_clr_seq #(
  parameter int aw    = 8,
  parameter bit CLEAR = 1'b1
)(
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [aw-1:0] addr,
  output logic          active,
  output logic          done
);

  logic [aw-1:0] cnt;
  logic          busy;

  // Count while busy; the last word drops busy and the counter wraps back to 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt  <= '0;
      busy <= CLEAR;
    end else if (busy) begin
      cnt <= cnt + aw'(1);
      if (&cnt) busy <= 1'b0;
    end
  end

  assign addr   = cnt;
  assign active = busy;
  assign done   = busy & (&cnt);

endmodule

// File: rtl/qerv_rf_ram_sched.sv
// Scheduler between the core RF-RAM interface and the single SRAM.
// Clears the RAM after reset, then passes the core straight through and slots
// debug/loader accesses into cycles where the core leaves a port idle.
module qerv_rf_ram_sched
  import qerv_rf_pkg::*;
#(
  parameter  int width    = 8,
  parameter  int csr_regs = 4,
  parameter  bit CLEAR    = 1'b1,
  localparam int aw       = rf_aw(width, csr_regs)
)(
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_init_done,
  input  logic [aw-1:0]    i_c_waddr,
  input  logic [width-1:0] i_c_wdata,
  input  logic             i_c_wen,
  input  logic [aw-1:0]    i_c_raddr,
  input  logic             i_c_ren,
  output logic [width-1:0] o_c_rdata,
  input  logic             i_dbg_req,
  input  logic             i_dbg_we,
  input  logic [aw-1:0]    i_dbg_addr,
  input  logic [width-1:0] i_dbg_wdata,
  output logic             o_dbg_ack,
  output logic [width-1:0] o_dbg_rdata,
  output logic [aw-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [aw-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [width-1:0] i_rdata
);

  state_t           state, state_n;
  dstate_t          dstate, dstate_n;
  logic [aw-1:0]    clr_addr;
  logic             clr_active, clr_done;
  logic             run, wr_go, rd_go, dbg_rd;
  logic [width-1:0] dbg_rdata_q;

  qerv_rf_clr_seq #(.aw(aw), .CLEAR(CLEAR)) u_clr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .addr   (clr_addr),
    .active (clr_active),
    .done   (clr_done)
  );

  // Reset forces every strobe low, even in the reset cycle itself.
  assign run   = (state == S_RUN) && !i_rst;
  // Debug only claims a port the core is not using this cycle; the core is never stalled.
  assign wr_go = run && (dstate == D_IDLE) && i_dbg_req &&  i_dbg_we && !i_c_wen;
  assign rd_go = run && (dstate == D_IDLE) && i_dbg_req && !i_dbg_we && !i_c_ren;

  // Main state register: CLEAR after reset unless clearing is disabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= CLEAR ? S_CLEAR : S_RUN;
    else       state <= state_n;
  end

  // Leave CLEAR once the sequencer has written its last word.
  always_comb begin
    state_n = state;
    if (state == S_CLEAR && clr_done) state_n = S_RUN;
  end

  // Debug state, read/write flag of the access in flight, and held read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dstate      <= D_IDLE;
      dbg_rd      <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      dstate <= dstate_n;
      if (wr_go || rd_go) dbg_rd <= rd_go;
      if (dstate == D_WAIT && dbg_rd) dbg_rdata_q <= i_rdata;
    end
  end

  // Issue moves to WAIT; WAIT is the single ack cycle and always returns to IDLE.
  always_comb begin
    dstate_n = dstate;
    case (dstate)
      D_IDLE: if (wr_go || rd_go) dstate_n = D_WAIT;
      D_WAIT: dstate_n = D_IDLE;
      default: dstate_n = D_IDLE;
    endcase
  end

  // Write port: clear sweep, else core, else a pending debug write.
  always_comb begin
    o_wen   = 1'b0;
    o_waddr = i_c_waddr;
    o_wdata = i_c_wdata;
    if (i_rst) begin
      o_wen = 1'b0;
    end else if (clr_active) begin
      o_wen   = 1'b1;
      o_waddr = clr_addr;
      o_wdata = '0;
    end else if (run && i_c_wen) begin
      o_wen = 1'b1;
    end else if (wr_go) begin
      o_wen   = 1'b1;
      o_waddr = i_dbg_addr;
      o_wdata = i_dbg_wdata;
    end
  end

  // Read port: core first, else a pending debug read.
  always_comb begin
    o_ren   = 1'b0;
    o_raddr = i_c_raddr;
    if (run && i_c_ren) begin
      o_ren = 1'b1;
    end else if (rd_go) begin
      o_ren   = 1'b1;
      o_raddr = i_dbg_addr;
    end
  end

  assign o_init_done = run;
  assign o_c_rdata   = i_rdata;
  assign o_dbg_ack   = !i_rst && (dstate == D_WAIT);
  // Read data is visible in the ack cycle itself, then held until the next read ack.
  assign o_dbg_rdata = (o_dbg_ack && dbg_rd) ? i_rdata : dbg_rdata_q;

endmodule
